// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular FIFO feeding a frame serialiser
// (start, LSB-first data, optional parity, 1-2 stop bits) with back-to-back frames.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [DATA_BITS-1:0]                 wr_data,
    output logic                                 full,
    output logic                                 empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
    output logic                                 overrun,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 tx_out
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count_nxt;
    logic                 wr_ok, pop;

    state_t               state, state_nxt;
    logic [TICK_W-1:0]    tick_cnt, tick_nxt;
    logic [IDX_W-1:0]     bit_idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, sh_nxt;
    logic                 par_acc, par_nxt;
    logic                 tx_nxt, done_nxt, tick_last;

    assign wr_ok     = wr_en && !full;
    assign tick_last = (tick_cnt == TICK_W'(CLKS_PER_BIT - 1));

    // Occupancy after this edge; a simultaneous write and pop cancel out.
    always_comb begin
        count_nxt = count;
        case ({wr_ok, pop})
            2'b10:   count_nxt = CNT_W'(count + 1'b1);
            2'b01:   count_nxt = CNT_W'(count - 1'b1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            overrun <= 1'b0;
        end else begin
            overrun <= wr_en && full;
            if (wr_ok) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (pop)   rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            count   <= count_nxt;
            full    <= (count_nxt == CNT_W'(FIFO_DEPTH));
            empty   <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem[wr_ptr] <= wr_data;
    end

    // Serialiser next-state; pops happen from IDLE or straight out of the last stop bit.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_last ? '0 : TICK_W'(tick_cnt + 1'b1);
        idx_nxt   = bit_idx;
        sh_nxt    = shreg;
        par_nxt   = par_acc;
        pop       = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                tick_nxt = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    sh_nxt    = mem[rd_ptr];
                    par_nxt   = 1'b0;
                    idx_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick_last) begin
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tick_last) begin
                    sh_nxt  = shreg >> 1;
                    par_nxt = par_acc ^ shreg[0];
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_nxt = IDX_W'(bit_idx + 1'b1);
                    end
                end
            end
            PARITY: begin
                if (tick_last) begin
                    idx_nxt   = '0;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick_last) begin
                    if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        done_nxt = 1'b1;
                        idx_nxt  = '0;
                        if (!empty) begin
                            pop       = 1'b1;
                            sh_nxt    = mem[rd_ptr];
                            par_nxt   = 1'b0;
                            state_nxt = START;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = IDX_W'(bit_idx + 1'b1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = sh_nxt[0];
            PARITY:  tx_nxt = par_nxt ^ 1'(PARITY_ODD);
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_idx  <= idx_nxt;
            shreg    <= sh_nxt;
            par_acc  <= par_nxt;
            tx_out   <= tx_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= done_nxt;
        end
    end

endmodule
